param_coefficient_loader: RTL and testbench
===========================================

PARAM_COEFFICIENT_LOADER -- requirements
Module: param_coefficient_loader

Interface
REQ-001 Parameter NUM_COEFFS, default 4, meaning: number of coefficients loaded per set; legal range 1..256.
REQ-002 Parameter IDX_W, default 2, meaning: coefficient index width; SHALL equal max(1, clog2(NUM_COEFFS)).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 n_reset  input  1  asynchronous reset, active-low.
REQ-005 new_coefficient_set  input  1  request to load a full coefficient set; sampled every cycle.
REQ-006 modwait  input  1  downstream controller busy; no load issued while high.
REQ-007 abort  input  1  synchronous cancel of the current sequence and any pending request.
REQ-008 load_coeff  output  1  high one cycle per coefficient load.
REQ-009 coefficient_num  output  IDX_W  index of coefficient being (or last) loaded.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 load_done  output  1  one-cycle pulse after the final coefficient load.
REQ-012 pending  output  1  a request is queued and not yet started.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, WAIT, DONE plus an IDX_W-bit index register idx.
REQ-014 All outputs SHALL be Moore-decoded from state, idx and the pending register (no input-to-output combinational path).
REQ-015 IDLE: start condition = (new_coefficient_set or pending) and !modwait and !abort -> LOAD with idx=0, pending cleared.
REQ-016 IDLE with new_coefficient_set=1 and modwait=1 -> remain IDLE, pending set.
REQ-017 LOAD: load_coeff=1, coefficient_num=idx; next state DONE if idx==NUM_COEFFS-1, else WAIT.
REQ-018 WAIT: load_coeff=0, coefficient_num=idx; stay while modwait=1; when modwait=0 -> LOAD with idx=idx+1.
REQ-019 WAIT SHALL occupy at least one cycle between consecutive loads (no back-to-back load_coeff).
REQ-020 DONE: load_done=1, load_coeff=0, coefficient_num=NUM_COEFFS-1; next state IDLE unconditionally.
REQ-021 IDLE: load_coeff=0, coefficient_num=0, load_done=0.
REQ-022 new_coefficient_set asserted in LOAD, WAIT or DONE SHALL set pending; sequence in progress SHALL NOT restart.
REQ-023 Multiple requests while busy SHALL collapse into one pending request.
REQ-024 Pending request SHALL start from IDLE per REQ-015 (earliest one cycle after DONE).
REQ-025 abort=1 in any state SHALL force IDLE, idx=0, pending=0 next cycle, no load_done; abort has priority over every start or set condition.
REQ-026 idx SHALL never exceed NUM_COEFFS-1; no wrap-around within a sequence.
REQ-027 Latency: request in IDLE with modwait=0 -> load_coeff next cycle; with modwait held 0 a set completes in 2*NUM_COEFFS cycles (N LOAD + N-1 WAIT + 1 DONE).
REQ-028 NUM_COEFFS=1: sequence SHALL be IDLE -> LOAD -> DONE -> IDLE.

Reset
REQ-029 n_reset low SHALL immediately force state=IDLE, idx=0, pending=0, load_coeff=0, coefficient_num=0, busy=0, load_done=0, regardless of clk.
REQ-030 Reset mid-sequence SHALL discard the sequence and pending request; no load_done issued.
REQ-031 After n_reset deasserts, first request SHALL behave per REQ-015.

Verification
REQ-032 NUM_COEFFS=4, modwait=0, one-cycle new_coefficient_set -> load_coeff on cycles 1,3,5,7 with coefficient_num 0,1,2,3; load_done on cycle 8; busy cycles 1..8.
REQ-033 NUM_COEFFS=4, modwait high 3 cycles after each load -> each WAIT lasts 3 cycles, indices 0..3 in order, exactly 4 load_coeff pulses, one load_done.
REQ-034 Request while modwait=1 in IDLE -> pending=1, no load; modwait drops -> load_coeff with coefficient_num=0 next cycle, pending=0.
REQ-035 Two requests during active sequence -> pending=1; after load_done, exactly one further 4-load sequence, then idle.
REQ-036 abort during WAIT at idx=2 with pending=1 -> next cycle IDLE, busy=0, pending=0, no load_done, no further loads.
REQ-037 NUM_COEFFS=8 (IDX_W=3) and NUM_COEFFS=1 builds -> indices 0..7 respectively single load at index 0, each followed by one load_done; n_reset pulsed mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/param_coefficient_loader_if.sv
// Handshake bundle between a coefficient-load requester and the loader.
// The requester (master) raises load requests and flow control; the loader
// (slave) reports load strobes, the current index and its status flags.
interface param_coefficient_loader_if #(
  parameter int IDX_W = 2
);
  logic             new_coefficient_set;
  logic             modwait;
  logic             abort;
  logic             load_coeff;
  logic [IDX_W-1:0] coefficient_num;
  logic             busy;
  logic             load_done;
  logic             pending;

  modport master (
    output new_coefficient_set, modwait, abort,
    input  load_coeff, coefficient_num, busy, load_done, pending
  );

  modport slave (
    input  new_coefficient_set, modwait, abort,
    output load_coeff, coefficient_num, busy, load_done, pending
  );
endinterface

// File: rtl/param_coefficient_loader.sv
// Coefficient set loader: on request, strobes load_coeff once per coefficient
// (index 0..NUM_COEFFS-1), inserting at least one idle cycle between loads and
// stalling while the downstream controller reports modwait. A request that
// arrives while busy (or while modwait blocks the start) is remembered in a
// single pending flag. All outputs are decoded from registers only.
module param_coefficient_loader #(
  parameter int NUM_COEFFS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                      clk,
  input  logic                      n_reset,
  param_coefficient_loader_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_next;
  logic             pending_reg;
  logic             pending_next;
  logic             start;

  // A fresh request or a remembered one may start only when downstream is free.
  assign start = (bus.new_coefficient_set | pending_reg) & ~bus.modwait;

  // State, index and pending registers; reset acts immediately, without clk.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pending_reg <= pending_next;
    end
  end

  // Next-state logic; abort overrides every other transition and request.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pending_next = pending_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = LOAD;
          idx_next     = '0;
          pending_next = 1'b0;
        end else if (bus.new_coefficient_set) begin
          pending_next = 1'b1;
        end
      end
      LOAD: begin
        pending_next = pending_reg | bus.new_coefficient_set;
        // The final index goes straight to DONE, so idx never passes LAST_IDX.
        state_next   = (idx_reg == LAST_IDX) ? DONE : WAIT;
      end
      WAIT: begin
        pending_next = pending_reg | bus.new_coefficient_set;
        if (!bus.modwait) begin
          state_next = LOAD;
          idx_next   = idx_reg + IDX_W'(1);
        end
      end
      DONE: begin
        pending_next = pending_reg | bus.new_coefficient_set;
        state_next   = IDLE;
        idx_next     = '0;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
    if (bus.abort) begin
      state_next   = IDLE;
      idx_next     = '0;
      pending_next = 1'b0;
    end
  end

  // Moore output decode from state, index and pending flag.
  always_comb begin
    bus.load_coeff      = (state_reg == LOAD);
    bus.load_done       = (state_reg == DONE);
    bus.busy            = (state_reg != IDLE);
    bus.pending         = pending_reg;
    bus.coefficient_num = idx_reg;
    if (state_reg == IDLE) begin
      bus.coefficient_num = '0;
    end else if (state_reg == DONE) begin
      bus.coefficient_num = LAST_IDX;
    end
  end

endmodule

// File: tb/tb_param_coefficient_loader.sv
// Bench for the coefficient loader: three builds (4, 8 and 1 coefficients)
// share one randomized request/modwait/abort stream. A cycle-level reference
// model per build predicts load/done events into a queue that a negedge
// monitor drains; status outputs are checked every cycle, and asynchronous
// reset is checked to clear all outputs without a clock edge.
module tb_param_coefficient_loader;

  typedef struct {
    bit is_done;
    int idx;
  } ev_t;

  logic clk;
  logic n_reset;
  logic new_set;
  logic modwait;
  logic abort;

  int checks;
  int failures;
  event end_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g
      localparam int NC = (gi == 0) ? 4 : ((gi == 1) ? 8 : 1);
      localparam int IW = (NC > 1) ? $clog2(NC) : 1;

      param_coefficient_loader_if #(.IDX_W(IW)) bus ();

      assign bus.new_coefficient_set = new_set;
      assign bus.modwait             = modwait;
      assign bus.abort               = abort;

      param_coefficient_loader #(
        .NUM_COEFFS(NC),
        .IDX_W     (IW)
      ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus)
      );

      // Reference model state: loads issued in the current set (-1 = none),
      // whether the last cycle was a load, whether the set is finishing,
      // and whether a request is queued.
      int  issued = -1;
      bit  just_loaded = 1'b0;
      bit  finishing = 1'b0;
      bit  queued = 1'b0;
      bit  exp_busy = 1'b0;
      bit  exp_pend = 1'b0;
      int  exp_num = 0;
      int  dones = 0;
      ev_t sbq[$];

      always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          issued      = -1;
          just_loaded = 1'b0;
          finishing   = 1'b0;
          queued      = 1'b0;
          sbq.delete();
        end else if (abort) begin
          issued      = -1;
          just_loaded = 1'b0;
          finishing   = 1'b0;
          queued      = 1'b0;
        end else if (finishing) begin
          finishing = 1'b0;
          issued    = -1;
          queued    = queued | new_set;
        end else if (issued < 0) begin
          if ((new_set || queued) && !modwait) begin
            issued      = 1;
            just_loaded = 1'b1;
            queued      = 1'b0;
            sbq.push_back('{is_done: 1'b0, idx: 0});
          end else if (new_set) begin
            queued = 1'b1;
          end
        end else if (just_loaded) begin
          just_loaded = 1'b0;
          queued      = queued | new_set;
          if (issued == NC) begin
            finishing = 1'b1;
            sbq.push_back('{is_done: 1'b1, idx: NC - 1});
          end
        end else begin
          queued = queued | new_set;
          if (!modwait) begin
            sbq.push_back('{is_done: 1'b0, idx: issued});
            issued      = issued + 1;
            just_loaded = 1'b1;
          end
        end
        exp_busy = (issued >= 0);
        exp_pend = queued;
        exp_num  = (issued < 0) ? 0 : (finishing ? NC - 1 : issued - 1);
      end

      // Monitor: status every cycle, and load/done strobes against the queue.
      always @(negedge clk) begin
        ev_t ev;
        checks++;
        if (bus.busy !== exp_busy) begin
          failures++;
          $display("FAIL n%0d busy: got %0b want %0b t=%0t", NC, bus.busy, exp_busy, $time);
        end
        checks++;
        if (bus.pending !== exp_pend) begin
          failures++;
          $display("FAIL n%0d pending: got %0b want %0b t=%0t", NC, bus.pending, exp_pend, $time);
        end
        checks++;
        if (int'(bus.coefficient_num) != exp_num || $isunknown(bus.coefficient_num)) begin
          failures++;
          $display("FAIL n%0d coefficient_num: got %0d want %0d t=%0t", NC, bus.coefficient_num, exp_num, $time);
        end
        checks++;
        if (bus.load_coeff === 1'b1 || bus.load_done === 1'b1) begin
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL n%0d strobe: got load=%0b done=%0b want none t=%0t", NC, bus.load_coeff, bus.load_done, $time);
          end else begin
            ev = sbq.pop_front();
            if (bus.load_done !== ev.is_done || bus.load_coeff !== !ev.is_done ||
                int'(bus.coefficient_num) != ev.idx) begin
              failures++;
              $display("FAIL n%0d event: got load=%0b done=%0b idx=%0d want done=%0b idx=%0d t=%0t",
                       NC, bus.load_coeff, bus.load_done, bus.coefficient_num, ev.is_done, ev.idx, $time);
            end
            if (ev.is_done) dones++;
          end
        end else if (sbq.size() != 0) begin
          ev = sbq.pop_front();
          failures++;
          $display("FAIL n%0d missing: got no strobe want done=%0b idx=%0d t=%0t", NC, ev.is_done, ev.idx, $time);
        end
      end

      // Reset must clear every output immediately, independent of clk.
      always @(negedge n_reset) begin
        #1;
        checks++;
        if ({bus.load_coeff, bus.load_done, bus.busy, bus.pending} !== 4'b0000 ||
            bus.coefficient_num !== '0) begin
          failures++;
          $display("FAIL n%0d async_reset: got load=%0b done=%0b busy=%0b pend=%0b idx=%0d want all 0",
                   NC, bus.load_coeff, bus.load_done, bus.busy, bus.pending, bus.coefficient_num);
        end
      end

      // End-of-run: every predicted strobe was seen and sets did complete.
      always @(end_ev) begin
        checks++;
        if (sbq.size() != 0 || dones == 0) begin
          failures++;
          $display("FAIL n%0d final: got queued=%0d dones=%0d want queued=0 dones>0", NC, sbq.size(), dones);
        end
      end
    end
  endgenerate

  task automatic run_random(input int cycles, input int wait_pct, input int req_pct, input int abort_pct);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      new_set = ($urandom_range(0, 99) < req_pct);
      modwait = ($urandom_range(0, 99) < wait_pct);
      abort   = ($urandom_range(0, 999) < abort_pct);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    new_set  = 1'b0;
    modwait  = 1'b0;
    abort    = 1'b0;
    n_reset  = 1'b1;
    #3 n_reset = 1'b0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;

    // Single request, modwait low: full sets back to idle.
    @(negedge clk);
    new_set = 1'b1;
    @(negedge clk);
    new_set = 1'b0;
    repeat (20) @(negedge clk);

    // Request blocked by modwait, then released.
    modwait = 1'b1;
    new_set = 1'b1;
    @(negedge clk);
    new_set = 1'b0;
    repeat (3) @(negedge clk);
    modwait = 1'b0;
    repeat (20) @(negedge clk);

    // Two requests during an active set collapse into one follow-up set.
    new_set = 1'b1;
    @(negedge clk);
    new_set = 1'b0;
    repeat (2) @(negedge clk);
    new_set = 1'b1;
    @(negedge clk);
    @(negedge clk);
    new_set = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized traffic: light and heavy modwait, occasional abort.
    run_random(1500, 30, 15, 10);
    run_random(1500, 75, 10, 5);
    new_set = 1'b0;
    modwait = 1'b0;
    abort   = 1'b0;
    repeat (5) @(negedge clk);

    // Reset pulse in the middle of a set, off the clock edge.
    new_set = 1'b1;
    @(negedge clk);
    new_set = 1'b0;
    repeat (4) @(negedge clk);
    #2 n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);

    // After reset, a request starts normally.
    new_set = 1'b1;
    @(negedge clk);
    new_set = 1'b0;
    repeat (25) @(negedge clk);

    -> end_ev;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
